// File: rtl/tl_timed_cntr.sv
// Timed two-road traffic-light sequencer: state register, saturating dwell counter and Moore light decode.
// Optional pedestrian all-red walk phase is built only when TL_PED_WALK_EN is defined.
module tl_timed_cntr #(
    parameter int MIN_GRN  = 8,
    parameter int YEL_CYC  = 5,
    parameter int WALK_CYC = 6,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic       walk,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
`ifdef TL_PED_WALK_EN
        S3 = 3'd3,
        S4 = 3'd4
`else
        S3 = 3'd3
`endif
    } state_t;

    localparam logic [CNT_W-1:0] GRN_LAST  = CNT_W'(MIN_GRN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YEL_CYC - 1);
`ifdef TL_PED_WALK_EN
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_CYC - 1);
`endif

    state_t           r_state;
    state_t           w_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_ped_go;

`ifdef TL_PED_WALK_EN
    logic r_ped_pend;
    logic r_nxt_b;

    assign w_ped_go = r_ped_pend;

    // The request latch is cleared on walk entry before it can be re-set, so a
    // request coinciding with a yellow exit that is already diverting is absorbed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ped_pend <= 1'b0;
            r_nxt_b    <= 1'b0;
        end else begin
            if (w_nxt == S4 && r_state != S4)
                r_ped_pend <= 1'b0;
            else if (ped_req && r_state != S4)
                r_ped_pend <= 1'b1;
            if (r_state == S1 && r_cnt == YEL_LAST)
                r_nxt_b <= 1'b1;
            else if (r_state == S3 && r_cnt == YEL_LAST)
                r_nxt_b <= 1'b0;
        end
    end
`else
    logic w_unused_ped;
    assign w_unused_ped = ped_req;
    assign w_ped_go     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_nxt != r_state)
                r_cnt <= '0;
            else if (r_cnt != '1)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_nxt = S0;
        case (r_state)
            S0: w_nxt = (!Ta && r_cnt >= GRN_LAST) ? S1 : S0;
            S1: begin
                w_nxt = S1;
                if (r_cnt == YEL_LAST) begin
`ifdef TL_PED_WALK_EN
                    w_nxt = w_ped_go ? S4 : S2;
`else
                    w_nxt = S2;
`endif
                end
            end
            S2: w_nxt = (!Tb && r_cnt >= GRN_LAST) ? S3 : S2;
            S3: begin
                w_nxt = S3;
                if (r_cnt == YEL_LAST) begin
`ifdef TL_PED_WALK_EN
                    w_nxt = w_ped_go ? S4 : S0;
`else
                    w_nxt = S0;
`endif
                end
            end
`ifdef TL_PED_WALK_EN
            S4: begin
                w_nxt = S4;
                if (r_cnt == WALK_LAST)
                    w_nxt = r_nxt_b ? S2 : S0;
            end
`endif
            default: w_nxt = S0;
        endcase
    end

    // Moore decode; unused encodings fall through to both-red.
    always_comb begin
        La   = 2'b10;
        Lb   = 2'b10;
        walk = 1'b0;
        case (r_state)
            S0: La = 2'b00;
            S1: La = 2'b01;
            S2: Lb = 2'b00;
            S3: Lb = 2'b01;
`ifdef TL_PED_WALK_EN
            S4: walk = 1'b1;
`endif
            default: ;
        endcase
    end

`ifdef TL_PED_WALK_EN
    assign ped_ack = (r_state == S4) && (r_cnt == '0);
`else
    assign ped_ack = 1'b0;
    logic w_unused_go;
    assign w_unused_go = w_ped_go;
`endif

    assign state = r_state;

endmodule

// File: doc/tl_timed_cntr.md
# tl_timed_cntr

- Timed traffic-light sequencer for the two-road intersection (road A / road B).
- Owns the full state register, dwell counter and light decode, replacing the bare next-state logic plus external state register.
- Enforces a minimum green time, a fixed yellow time and, optionally, a pedestrian all-red walk phase with a request/acknowledge handshake.

## Interface
Parameters:
- MIN_GRN, 8: minimum cycles in each green state (≥1)
- YEL_CYC, 5: exact cycles in each yellow state (≥1)
- WALK_CYC, 6: exact cycles in the walk state (≥1)
- CNT_W, 4: dwell counter width; must hold max(MIN_GRN, YEL_CYC, WALK_CYC)-1

Ports:
- clk, input, 1: sole clock, rising edge
- reset, input, 1: synchronous, active-high reset
- Ta, input, 1: road A traffic sensor, 1 = cars present
- Tb, input, 1: road B traffic sensor, 1 = cars present
- ped_req, input, 1: pedestrian request, level or pulse
- ped_ack, output, 1: one-cycle acknowledge on walk entry
- La, output, 2: road A light (00 green, 01 yellow, 10 red)
- Lb, output, 2: road B light, same encoding
- walk, output, 1: pedestrian walk lamp
- state, output, 3: current state, for debug/observation

## Operation
- States:
  - S0 = 3'd0: A green, B red
  - S1 = 3'd1: A yellow, B red
  - S2 = 3'd2: A red, B green
  - S3 = 3'd3: A red, B yellow
  - S4 = 3'd4: walk, both red, walk=1 (exists only with macro)
- Dwell counter `cnt`:
  - cleared to 0 on every state change.
  - increments each cycle the state is held.
  - saturates at all-ones.
- S0 → S1 when Ta==0 and cnt ≥ MIN_GRN-1; otherwise stay. Ta is ignored until the minimum has elapsed.
- S1 → S2 (or S4, see below) when cnt == YEL_CYC-1.
- S2 → S3 when Tb==0 and cnt ≥ MIN_GRN-1; otherwise stay.
- S3 → S0 (or S4) when cnt == YEL_CYC-1.
- S4 → the green that would have followed the yellow, when cnt == WALK_CYC-1. A 1-bit `nxt_b` register, set on leaving a yellow, records which green (0 = S0, 1 = S2).
- Pedestrian latch `ped_pend`:
  - set when ped_req==1 in any state except S4.
  - cleared on S4 entry.
  - ped_req during S4 is ignored.
  - If ped_req is held high, it re-latches the cycle after S4 exits.
- Yellow exit goes to S4 if ped_pend==1 at the exit cycle.
- Simultaneous ped_req and yellow exit: the request does not divert that exit; it is latched and serviced at the next yellow.
- ped_ack is 1 only in the first cycle of S4 (cnt==0).
- La, Lb, walk and state are decoded from the state register only (Moore).
- Unused encodings 5–7: decode both lights red, walk=0, and go to S0 on the next edge.

## Timing
- Reset values on the edge sampling reset=1:
  - state=S0, cnt=0, ped_pend=0, nxt_b=0
  - outputs: La=00, Lb=10, walk=0, ped_ack=0
- Reset mid-operation: the next edge forces the full reset values regardless of state or counter. Any pending request is discarded.
- Outputs change in the same cycle as the state register; there is no extra latency.
- Sensor inputs are sampled at the clock edge; a change is acted on at the earliest at the next edge.
- Cycle 0 is the first cycle after reset deasserts.
- With Ta=Tb=0 continuously, defaults, no pedestrian:
  - S0: cycles 0–7
  - S1: cycles 8–12
  - S2: cycles 13–20
  - S3: cycles 21–25
  - S0: from cycle 26

## Configuration
- Macro: TL_PED_WALK_EN.
- Defined:
  - S4, ped_pend and nxt_b are present.
  - ped_ack and walk behave as in Operation.
- Undefined:
  - S4, ped_pend and nxt_b are not built.
  - ped_req is ignored.
  - ped_ack and walk are tied to 0.
  - Yellow always exits directly to the opposite green; state never shows 4.

## Test plan
- Reset, then Ta=1 for 100 cycles → state stays 0, La=00, Lb=10, walk=0 throughout.
- Ta=Tb=0 from cycle 0 → state sequence exactly as in Timing; La=01 in cycles 8–12; Lb=00 in cycles 13–20.
- Ta=1 until cycle 20, then Ta=0 → S1 entered at cycle 21, S2 at cycle 26.
- Macro on: Ta=0, Tb=1, ped_req pulsed at cycle 3:
  - S4 in cycles 13–18, walk=1 and La=Lb=10 there.
  - ped_ack=1 only at cycle 13.
  - S2 entered at cycle 19 and held while Tb=1.
- Ta=Tb=0, reset=1 for one cycle at cycle 10 (in S1) → at cycle 11 state=0, La=00, Lb=10; S1 re-entered at cycle 19.
- Macro off: ped_req held 1, Ta=Tb=0 → walk=0 and ped_ack=0 always; state sequence identical to the second scenario.
